// File: rtl/sccb_reg_sequencer.sv
// rtl/sccb_reg_sequencer.sv - walks a {reg,val} ROM and writes each entry to the sensor over SCCB
// Optional SCCB_DELAY_CMD_EN: ROM word 16'hFFF0 becomes a DELAY_CYCLES bus-idle wait.
module sccb_reg_sequencer #(
  parameter int unsigned CLK_DIV      = 250,
  parameter logic [7:0]  DEVICE_ID    = 8'h42,
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DELAY_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              sioc,
  output logic              siod,
  output logic              siod_oe,
  output logic              busy,
  output logic              done
);

  localparam int unsigned    DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

`ifdef SCCB_DELAY_CMD_EN
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_START, S_BITS, S_STOP, S_GAP, S_DELAY, S_DONE
  } state_t;
`else
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_START, S_BITS, S_STOP, S_GAP, S_DONE
  } state_t;
`endif

  state_t           state, next_state;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       quarter;
  logic [4:0]       bit_cnt;
  logic [26:0]      shreg;
  logic             tick;
  logic             last_addr;
  logic             dont_care;

  assign tick      = (div_cnt == DIV_LAST);
  assign last_addr = &rom_addr;
  // ACK slots of the three 9-bit phases are released to the sensor
  assign dont_care = (bit_cnt == 5'd8) || (bit_cnt == 5'd17) || (bit_cnt == 5'd26);

`ifdef SCCB_DELAY_CMD_EN
  localparam int unsigned DLY_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  logic [DLY_W-1:0] dly_cnt;
  logic             dly_done;

  assign dly_done = (dly_cnt == DLY_W'(DELAY_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      dly_cnt <= '0;
    else if (state != S_DELAY)
      dly_cnt <= '0;
    else
      dly_cnt <= dly_cnt + DLY_W'(1);
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE: if (start) next_state = S_FETCH;
      S_FETCH:        next_state = S_DECODE;
      S_DECODE: begin
        if (rom_data == 16'hFFFF)
          next_state = S_DONE;
`ifdef SCCB_DELAY_CMD_EN
        else if (rom_data == 16'hFFF0)
          next_state = S_DELAY;
`endif
        else
          next_state = S_START;
      end
      S_START: if (tick && quarter == 2'd1) next_state = S_BITS;
      S_BITS:  if (tick && quarter == 2'd3 && bit_cnt == 5'd26) next_state = S_STOP;
      S_STOP:  if (tick && quarter == 2'd2) next_state = S_GAP;
      S_GAP:   if (tick && quarter == 2'd3) next_state = last_addr ? S_DONE : S_FETCH;
`ifdef SCCB_DELAY_CMD_EN
      S_DELAY: if (dly_done) next_state = S_FETCH;
`endif
      default: next_state = S_IDLE;
    endcase
  end

  // Quarter/bit timing restarts on every state change
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt  <= '0;
      quarter  <= '0;
      bit_cnt  <= '0;
      shreg    <= '1;
      rom_addr <= '0;
    end else begin
      if (next_state != state) begin
        div_cnt <= '0;
        quarter <= '0;
        bit_cnt <= '0;
      end else if (tick) begin
        div_cnt <= '0;
        quarter <= quarter + 2'd1;
        if (state == S_BITS && quarter == 2'd3) begin
          bit_cnt <= bit_cnt + 5'd1;
          shreg   <= {shreg[25:0], 1'b1};
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end

      if (state == S_DECODE)
        shreg <= {DEVICE_ID[7:1], 1'b0, 1'b1, rom_data[15:8], 1'b1, rom_data[7:0], 1'b1};

      if ((state == S_IDLE || state == S_DONE) && start)
        rom_addr <= '0;
      else if (state == S_GAP && next_state == S_FETCH)
        rom_addr <= rom_addr + ADDR_W'(1);
`ifdef SCCB_DELAY_CMD_EN
      else if (state == S_DELAY && next_state == S_FETCH)
        rom_addr <= rom_addr + ADDR_W'(1);
`endif
    end
  end

  always_comb begin
    sioc    = 1'b1;
    siod    = 1'b1;
    siod_oe = 1'b1;
    busy    = 1'b1;
    done    = 1'b0;
    case (state)
      S_IDLE: busy = 1'b0;
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      S_START: siod = (quarter == 2'd0);
      S_BITS: begin
        sioc = (quarter == 2'd1) || (quarter == 2'd2);
        if (dont_care)
          siod_oe = 1'b0;
        else
          siod = shreg[26];
      end
      S_STOP: begin
        sioc = (quarter != 2'd0);
        siod = (quarter == 2'd2);
      end
      default: ;
    endcase
  end

endmodule

// File: doc/sccb_reg_sequencer.md
# sccb_reg_sequencer

Table-driven SCCB master that programs the camera's register set after power-up or on request. It walks a synchronous register ROM of `{reg_addr, reg_value}` words and serializes each entry as a 3-phase SCCB write to the sensor on `sioc`/`siod`. It runs in the `video_clk` domain and drives the camera PMOD SCCB pins directly. `done` releases downstream logic, such as capture and address generation, only once the sensor is configured.

## Interface
Parameters:
- `CLK_DIV`, default 250: `clk` cycles per SCCB quarter-bit. 250 gives 100 kHz SCL at 100 MHz.
- `DEVICE_ID`, default 8'h42: 8-bit SCCB write ID, sent with LSB = 0.
- `ADDR_W`, default 8: ROM address width.
- `DELAY_CYCLES`, default 1_000_000: wait length for a delay entry.

Ports:
- `clk`, in, 1: system clock (`video_clk`).
- `reset`, in, 1: asynchronous, active-high.
- `start`, in, 1: level request to run the table.
- `rom_addr`, out, `ADDR_W`: ROM read address.
- `rom_data`, in, 16: `{reg[15:8], val[7:0]}`, valid 1 cycle after `rom_addr`.
- `sioc`, out, 1: SCCB clock.
- `siod`, out, 1: SCCB data value.
- `siod_oe`, out, 1: 1 = drive `siod`, 0 = release (don't-care bit).
- `busy`, out, 1: high from start accept until DONE.
- `done`, out, 1: high after the table completes, until the next accepted start.

## Operation
Reset values: `sioc`=1, `siod`=1, `siod_oe`=1, `busy`=0, `done`=0, `rom_addr`=0, state IDLE.

State flow:
- **IDLE/DONE:** `start`=1 → clear `rom_addr`, set `busy`=1, clear `done`, go to FETCH. In any other state `start` is ignored.
- **FETCH:** 1 cycle of ROM latency, then DECODE.
- **DECODE** (ROM word rules):
  - 16'hFFFF → DONE (sentinel).
  - 16'hFFF0 → DELAY; only with `SCCB_DELAY_CMD_EN`, else sent as a normal write.
  - anything else → load the 27-bit shift register `{DEVICE_ID,X, reg,X, val,X}`, go to START.
- **START** (2 quarters): q0 `sioc`=1, `siod`=1; q1 `siod`=0, `sioc`=1.
- **BITS** (27 bits × 4 quarters, MSB first):
  - q0: `sioc`=0, present the bit on `siod`.
  - q1–q2: `sioc`=1.
  - q3: `sioc`=0.
  - Bits 9, 18 and 27 (don't-care): `siod_oe`=0 for all 4 quarters, `siod`=1. The ACK is not checked.
- **STOP** (3 quarters): (`sioc`=0, `siod`=0) → (`sioc`=1, `siod`=0) → (`sioc`=1, `siod`=1).
- **GAP:** 4 quarters with the bus idle high. Then:
  - `rom_addr` = 2^ADDR_W−1 → DONE (end of ROM without sentinel).
  - otherwise `rom_addr`+1, then FETCH.
- **DELAY:** count `DELAY_CYCLES`, `rom_addr`+1, then FETCH.
- **DONE:** `busy`=0, `done`=1, bus idle high.

## Timing
- Quarter tick: a counter over 0..`CLK_DIV`−1 that restarts on every state entry.
- One write = 2+108+3+4 = 117 quarters = 117·`CLK_DIV` cycles.
- Per-entry overhead: FETCH + DECODE = 2 cycles. Total per entry = 117·`CLK_DIV`+2.
- `siod` changes only while `sioc`=0, except the START and STOP edges.
- `busy` rises the cycle after `start` is sampled. `done` rises the cycle DONE is entered.
- Reset mid-transfer: all outputs return to reset values the same cycle (asynchronous). The bus is left idle high with no STOP generated.

## Configuration
- `SCCB_DELAY_CMD_EN` defined: ROM word 16'hFFF0 inserts a `DELAY_CYCLES` wait with no bus activity. Used for the post-soft-reset (reg 0x12=0x80) settle time.
- Undefined: no DELAY state and no delay counter is built. 16'hFFF0 is sent as a normal write of reg 0xFF, value 0xF0.

## Test plan
1. **Basic table.** `CLK_DIV`=2, ROM = {16'h1280, 16'h1204, 16'hFFFF}, pulse `start`. Required response:
   - Two writes decoded off the bus: 0x42/0x12/0x80 and 0x42/0x12/0x04.
   - `siod_oe`=0 only on bits 9, 18 and 27.
   - `done`=1 at 2·(234+2)+2 cycles ±1.
2. **Start while busy.** Hold `start`=1 throughout test 1. Required: exactly one pass is made, then a second pass begins the cycle after DONE.
3. **Delay entry.** Requires `SCCB_DELAY_CMD_EN`. `DELAY_CYCLES`=50, ROM = {16'hFFF0, 16'h1100, 16'hFFFF}. Required: `sioc` stays high for 50 cycles, then one write 0x42/0x11/0x00. Without the macro, the first write is 0x42/0xFF/0xF0.
4. **No sentinel.** `ADDR_W`=2, ROM has 4 normal entries. Required: 4 writes, then `done`=1 without `rom_addr` wrapping to 0.
5. **Reset mid-transfer.** Assert `reset` during BITS of entry 0. Required:
   - Same cycle: `sioc`=`siod`=1, `busy`=0, `rom_addr`=0.
   - A later `start` replays the table from entry 0.
6. **Protocol check.** Monitor `siod` across every write. Required: no `siod` edge while `sioc`=1, except exactly one falling edge (START) and one rising edge (STOP) per write.
